// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the IFU (read-only)
// and the LSU (read/write). One outstanding transaction; request fields are registered.
//
// Handshake semantics: a requester holds *_req_valid and its fields stable until the
// cycle *_req_ready pulses (combinational, IDLE only). Downstream, m_req_* is held
// stable while m_req_valid is high and completes in the cycle m_req_ready is high.
// m_resp_valid is a single-cycle pulse honoured only in RESP, where it is forwarded
// the same cycle to the owner's *_resp_valid / *_resp_rdata.
module ysyx_23060077_riscv_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    ifu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_req_ready,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_resp_rdata,

  input  logic                    lsu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_req_ready,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_resp_rdata,

  output logic                    m_req_valid,
  input  logic                    m_req_ready,
  output logic [ADDR_WIDTH-1:0]   m_req_addr,
  output logic                    m_req_wen,
  output logic [DATA_WIDTH-1:0]   m_req_wdata,
  output logic [DATA_WIDTH/8-1:0] m_req_wmask,
  input  logic                    m_resp_valid,
  input  logic [DATA_WIDTH-1:0]   m_resp_rdata,

  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  state_t state;
  state_t state_nxt;
  owner_t owner;
  logic   last_lsu;
  logic   grant_ifu;
  logic   grant_lsu;
  logic   resp_fire;

  // Ties go to the side that was not granted last; rst_n gating keeps ready low in reset.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      if (ifu_req_valid && (!lsu_req_valid || last_lsu)) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign resp_fire = (state == S_RESP) && m_resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_ifu || grant_lsu) state_nxt = S_REQ;
      S_REQ:   if (m_req_ready) state_nxt = S_RESP;
      S_RESP:  if (m_resp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture and ownership; fields stay frozen until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= OWN_NONE;
      last_lsu    <= 1'b1;
      m_req_valid <= 1'b0;
      m_req_addr  <= '0;
      m_req_wen   <= 1'b0;
      m_req_wdata <= '0;
      m_req_wmask <= '0;
    end else if (grant_ifu) begin
      owner       <= OWN_IFU;
      last_lsu    <= 1'b0;
      m_req_valid <= 1'b1;
      m_req_addr  <= ifu_req_addr;
      m_req_wen   <= 1'b0;
      m_req_wdata <= '0;
      m_req_wmask <= '0;
    end else if (grant_lsu) begin
      owner       <= OWN_LSU;
      last_lsu    <= 1'b1;
      m_req_valid <= 1'b1;
      m_req_addr  <= lsu_req_addr;
      m_req_wen   <= lsu_req_wen;
      m_req_wdata <= lsu_req_wdata;
      m_req_wmask <= lsu_req_wmask;
    end else if ((state == S_REQ) && m_req_ready) begin
      m_req_valid <= 1'b0;
    end else if (resp_fire) begin
      owner <= OWN_NONE;
    end
  end

  always_comb begin
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    ifu_resp_valid = resp_fire && (owner == OWN_IFU);
    lsu_resp_valid = resp_fire && (owner == OWN_LSU);
    ifu_resp_rdata = ifu_resp_valid ? m_resp_rdata : '0;
    lsu_resp_rdata = lsu_resp_valid ? m_resp_rdata : '0;
    dbg_state      = state;
  end

endmodule

// File: tb/tb_ysyx_23060077_riscv_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: requester drivers, a downstream
// memory model and a scoreboard monitor comparing grants, requests and responses.
module tb_ysyx_23060077_riscv_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MW     = DW / 8;
  localparam int MREQ_W = AW + 1 + DW + MW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } lsu_cmd_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_resp_rdata;
  logic          lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_resp_rdata;
  logic [MW-1:0] lsu_req_wmask;
  logic          m_req_valid, m_req_ready, m_req_wen;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_req_wdata;
  logic [MW-1:0] m_req_wmask;
  logic          m_resp_valid;
  logic [DW-1:0] m_resp_rdata;
  logic [1:0]    dbg_state;

  logic          mdl_resp_valid, inj_resp_valid;
  logic [DW-1:0] mdl_resp_rdata, inj_resp_rdata;
  assign m_resp_valid = mdl_resp_valid | inj_resp_valid;
  assign m_resp_rdata = inj_resp_valid ? inj_resp_rdata : mdl_resp_rdata;

  ysyx_23060077_riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [AW-1:0]     ifu_cmd_q[$];
  lsu_cmd_t          lsu_cmd_q[$];
  logic              exp_grant_q[$];
  logic [MREQ_W-1:0] exp_m_q[$];
  logic [DW-1:0]     rsp_q[$];
  logic [DW-1:0]     exp_ifu_q[$];
  logic [DW-1:0]     exp_lsu_q[$];
  int checks = 0;
  int errors = 0;
  int stall_cfg = 0;
  bit hold_resp = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s got unexpected event exp none", name);
  endtask

  task automatic expect_txn(input logic is_lsu, input logic [AW-1:0] addr, input logic wen,
                            input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                            input logic [DW-1:0] rdata, input logic resp);
    exp_grant_q.push_back(is_lsu);
    exp_m_q.push_back({addr, wen, wdata, wmask});
    if (resp) begin
      rsp_q.push_back(rdata);
      if (is_lsu) exp_lsu_q.push_back(rdata);
      else exp_ifu_q.push_back(rdata);
    end
  endtask

  // driver tasks: requesters hold valid until the ready pulse is seen
  initial begin
    bit hs;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    forever begin
      @(negedge clk);
      hs = ifu_req_valid && ifu_req_ready;
      @(posedge clk); #1;
      if (hs) ifu_req_valid = 1'b0;
      if (!ifu_req_valid && rst_n && ifu_cmd_q.size() > 0) begin
        ifu_req_addr  = ifu_cmd_q.pop_front();
        ifu_req_valid = 1'b1;
      end
    end
  end

  initial begin
    bit hs;
    lsu_cmd_t c;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_wmask = '0;
    forever begin
      @(negedge clk);
      hs = lsu_req_valid && lsu_req_ready;
      @(posedge clk); #1;
      if (hs) lsu_req_valid = 1'b0;
      if (!lsu_req_valid && rst_n && lsu_cmd_q.size() > 0) begin
        c = lsu_cmd_q.pop_front();
        lsu_req_addr  = c.addr;
        lsu_req_wen   = c.wen;
        lsu_req_wdata = c.wdata;
        lsu_req_wmask = c.wmask;
        lsu_req_valid = 1'b1;
      end
    end
  end

  // downstream memory model: optional stall, response in the first RESP cycle
  initial begin
    bit hs;
    int stall_left;
    m_req_ready    = 1'b0;
    mdl_resp_valid = 1'b0;
    mdl_resp_rdata = '0;
    stall_left     = 0;
    forever begin
      @(negedge clk);
      hs = m_req_valid && m_req_ready;
      @(posedge clk); #1;
      mdl_resp_valid = 1'b0;
      if (hs && !hold_resp && rsp_q.size() > 0) begin
        mdl_resp_valid = 1'b1;
        mdl_resp_rdata = rsp_q.pop_front();
      end
      if (m_req_valid) begin
        if (stall_left > 0) begin
          m_req_ready = 1'b0;
          stall_left--;
        end else begin
          m_req_ready = 1'b1;
        end
      end else begin
        m_req_ready = 1'b0;
        stall_left  = stall_cfg;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_side", 128'({ifu_req_ready, lsu_req_ready, m_req_valid, m_req_addr,
                                  m_req_wen, m_req_wdata, m_req_wmask}), 128'(0));
      check("rst_resp_side", 128'({ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid,
                                   lsu_resp_rdata}), 128'(0));
    end else begin
      if (ifu_req_ready || lsu_req_ready) begin
        check("single_grant", 128'(ifu_req_ready & lsu_req_ready), 128'(0));
        if (exp_grant_q.size() == 0) unexpected("grant");
        else check("grant_side", 128'(lsu_req_ready), 128'(exp_grant_q.pop_front()));
      end
      if (m_req_valid) begin
        if (exp_m_q.size() == 0) unexpected("m_req");
        else begin
          check("m_req_fields", 128'({m_req_addr, m_req_wen, m_req_wdata, m_req_wmask}),
                128'(exp_m_q[0]));
          if (m_req_ready) exp_m_q.delete(0);
        end
      end
      if (ifu_resp_valid) begin
        if (exp_ifu_q.size() == 0) unexpected("ifu_resp");
        else check("ifu_rdata", 128'(ifu_resp_rdata), 128'(exp_ifu_q.pop_front()));
      end
      if (lsu_resp_valid) begin
        if (exp_lsu_q.size() == 0) unexpected("lsu_resp");
        else check("lsu_rdata", 128'(lsu_resp_rdata), 128'(exp_lsu_q.pop_front()));
      end
      if (m_resp_valid) begin
        if (!ifu_resp_valid) check("ifu_rdata_unrouted", 128'(ifu_resp_rdata), 128'(0));
        if (!lsu_resp_valid) check("lsu_rdata_unrouted", 128'(lsu_resp_rdata), 128'(0));
      end
    end
  end

  function automatic int pending();
    return exp_grant_q.size() + exp_m_q.size() + exp_ifu_q.size() + exp_lsu_q.size();
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pending() > 0) unexpected("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_mreq(input int budget);
    int n = 0;
    while (!m_req_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!m_req_valid) unexpected("m_req_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    inj_resp_valid = 1'b0;
    inj_resp_rdata = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single IFU fetch at minimum latency
    @(negedge clk);
    expect_txn(1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'h0000_0413, 1'b1);
    ifu_cmd_q.push_back(32'h8000_0000);
    n = 0;
    while (!ifu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_ifu_ready", 128'(ifu_req_ready), 128'(1));
    @(negedge clk);
    check("t1_m_req", 128'({m_req_valid, m_req_addr, m_req_wen}), 128'({1'b1, 32'h8000_0000, 1'b0}));
    @(negedge clk);
    check("t1_resp", 128'({ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid}),
          128'({1'b1, 32'h0000_0413, 1'b0}));
    wait_drain(50);

    // simultaneous requests right after reset: IFU first, then the LSU store
    do_reset();
    @(negedge clk);
    expect_txn(1'b0, 32'h8000_0004, 1'b0, '0, '0, 32'h00A0_0093, 1'b1);
    expect_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b1);
    ifu_cmd_q.push_back(32'h8000_0004);
    lsu_cmd_q.push_back('{addr: 32'h8000_1000, wen: 1'b1, wdata: 32'hDEAD_BEEF, wmask: 4'hF});
    wait_drain(100);

    // six transactions with both sides always pending: strict alternation
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      expect_txn(1'b0, 32'h8000_0100 + 32'(i * 4), 1'b0, '0, '0, 32'h1100_0000 + 32'(i), 1'b1);
      expect_txn(1'b1, 32'h8000_2000 + 32'(i * 8), i[0], (i[0] ? 32'hA5A5_0000 : 32'h0),
                 (i[0] ? 4'h3 : 4'h0), 32'h2200_0000 + 32'(i), 1'b1);
      ifu_cmd_q.push_back(32'h8000_0100 + 32'(i * 4));
      lsu_cmd_q.push_back('{addr: 32'h8000_2000 + 32'(i * 8), wen: i[0],
                            wdata: (i[0] ? 32'hA5A5_0000 : 32'h0), wmask: (i[0] ? 4'h3 : 4'h0)});
    end
    wait_drain(200);

    // downstream stall: fields stable, LSU gets no ready while IFU owns the port
    stall_cfg = 4;
    @(negedge clk);
    expect_txn(1'b0, 32'h8000_0200, 1'b0, '0, '0, 32'h3300_0001, 1'b1);
    ifu_cmd_q.push_back(32'h8000_0200);
    wait_mreq(20);
    expect_txn(1'b1, 32'h8000_3000, 1'b1, 32'h0BAD_F00D, 4'h6, 32'h4400_0002, 1'b1);
    lsu_cmd_q.push_back('{addr: 32'h8000_3000, wen: 1'b1, wdata: 32'h0BAD_F00D, wmask: 4'h6});
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      check("busy_no_lsu_ready", 128'(lsu_req_ready), 128'(0));
      n++;
    end
    wait_drain(100);
    stall_cfg = 0;

    // stray response pulse in IDLE
    @(posedge clk); #1;
    inj_resp_valid = 1'b1;
    inj_resp_rdata = 32'hFFFF_0001;
    @(posedge clk); #1;
    inj_resp_valid = 1'b0;
    @(negedge clk);
    check("idle_glitch_state", 128'(dbg_state), 128'(2'd0));

    // stray response pulse in REQ, then a legitimate response
    stall_cfg = 3;
    @(negedge clk);
    expect_txn(1'b0, 32'h8000_0300, 1'b0, '0, '0, 32'h5500_0003, 1'b1);
    ifu_cmd_q.push_back(32'h8000_0300);
    wait_mreq(20);
    @(posedge clk); #1;
    inj_resp_valid = 1'b1;
    inj_resp_rdata = 32'hFFFF_0002;
    @(posedge clk); #1;
    inj_resp_valid = 1'b0;
    @(negedge clk);
    check("req_glitch_state", 128'({dbg_state, m_req_valid}), 128'({2'd1, 1'b1}));
    wait_drain(100);
    stall_cfg = 0;

    // reset while waiting for the response; stale response on release is dropped
    hold_resp = 1'b1;
    @(negedge clk);
    expect_txn(1'b0, 32'h8000_0400, 1'b0, '0, '0, '0, 1'b0);
    ifu_cmd_q.push_back(32'h8000_0400);
    n = 0;
    while (dbg_state != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_resp", 128'(dbg_state), 128'(2'd2));
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n          = 1'b1;
    hold_resp      = 1'b0;
    inj_resp_valid = 1'b1;
    inj_resp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("t6_no_stale_resp", 128'({ifu_resp_valid, lsu_resp_valid}), 128'(0));
    @(posedge clk); #1;
    inj_resp_valid = 1'b0;
    @(negedge clk);
    check("t6_idle_after_reset", 128'(dbg_state), 128'(2'd0));
    expect_txn(1'b0, 32'h8000_0408, 1'b0, '0, '0, 32'h6600_0004, 1'b1);
    ifu_cmd_q.push_back(32'h8000_0408);
    wait_drain(100);

    check("queues_empty", 128'(pending() + rsp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_23060077_riscv_mem_arbiter.md
Name: ysyx_23060077_riscv_mem_arbiter

Overview:
- Two-requester arbiter sharing one memory port between the instruction-fetch side (IFU, read-only) and the load/store side (LSU, read/write).
- Sits between the core's IFU/LSU and the single downstream memory interface (DPI memory model or bus bridge).
- Serialises transactions, with one outstanding transaction at a time.
- Uses round-robin priority, so neither side starves.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8; mask width MASK_W = DATA_WIDTH/8.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  IFU fetch request; held stable until ifu_req_ready.
- ifu_req_addr  in  ADDR_WIDTH  fetch address.
- ifu_req_ready  out  1  one-cycle pulse: IFU request captured.
- ifu_resp_valid  out  1  one-cycle pulse: fetch data valid.
- ifu_resp_rdata  out  DATA_WIDTH  fetched instruction word.
- lsu_req_valid  in  1  LSU request; held stable until lsu_req_ready.
- lsu_req_addr  in  ADDR_WIDTH  load/store address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  DATA_WIDTH  store data.
- lsu_req_wmask  in  MASK_W  store byte enables.
- lsu_req_ready  out  1  one-cycle pulse: LSU request captured.
- lsu_resp_valid  out  1  one-cycle pulse: load data valid / store complete.
- lsu_resp_rdata  out  DATA_WIDTH  load data (don't-care for stores).
- m_req_valid  out  1  downstream request valid.
- m_req_ready  in  1  downstream accepts request.
- m_req_addr  out  ADDR_WIDTH  registered address.
- m_req_wen  out  1  registered write enable (0 for IFU).
- m_req_wdata  out  DATA_WIDTH  registered store data (0 for IFU).
- m_req_wmask  out  MASK_W  registered mask (0 for IFU).
- m_resp_valid  in  1  downstream response pulse.
- m_resp_rdata  in  DATA_WIDTH  downstream read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; owner = NONE; last_grant = LSU, so the IFU wins the first tie.
  - All m_req_* registers = 0.
  - All ready/valid outputs = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the side opposite last_grant.
  - On grant: pulse that side's *_req_ready combinationally in this cycle; capture addr/wen/wdata/wmask into m_req_* (IFU: wen = 0, wdata = 0, wmask = 0); set owner and last_grant; next state = REQ.
  - With no valid requester, remain in IDLE.
- REQ:
  - m_req_valid = 1 (registered, asserted the cycle after grant); m_req_* fields are held stable.
  - When m_req_ready = 1, next state = RESP and m_req_valid drops the following cycle.
- RESP:
  - m_req_valid = 0; wait for m_resp_valid.
  - On m_resp_valid: forward to the owner in the same cycle (owner_resp_valid = 1, owner_resp_rdata = m_resp_rdata); owner = NONE; next state = IDLE.
- Minimum latency from requester valid to response:
  - 3 cycles: grant, m handshake, response.
  - Achieved when m_req_ready = 1 in the first REQ cycle and m_resp_valid = 1 in the first RESP cycle.
- New-request timing: a new grant may occur in the IDLE cycle directly after a response, so back-to-back transactions have one idle gap.
- *_resp_rdata = m_resp_rdata when routed to that owner, else 0. The non-owner's resp_valid is never asserted.
- m_resp_valid in IDLE or REQ is ignored; no response is routed, and it does not change state.
- A requester deasserting valid before ready is illegal and need not be handled. Once granted, the captured request completes regardless of later requester inputs.
- Reset asserted mid-transaction: the transaction is abandoned, all outputs return to reset values immediately, and no response is delivered after reset.
- Store responses: lsu_resp_valid pulses on m_resp_valid exactly as for loads.

Test Plan:
- IFU only, addr 0x8000_0000; m_req_ready = 1, m_resp_valid next cycle with rdata 0x0000_0413:
  - ifu_req_ready at cycle 0; m_req_valid at cycle 1 with addr 0x8000_0000 and wen 0.
  - ifu_resp_valid at cycle 2 with rdata 0x0000_0413; lsu_resp_valid stays 0.
- Both valid after reset (IFU 0x8000_0004, LSU store 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF):
  - IFU is granted first and LSU second.
  - The second m_req carries wen 1, wdata 0xDEAD_BEEF, wmask 0xF.
- Both continuously valid for 6 transactions:
  - Grants alternate IFU, LSU, IFU, LSU, IFU, LSU.
- m_req_ready held 0 for 4 cycles, then 1:
  - m_req_valid and all fields are stable throughout.
  - The opposite requester receives no ready while busy.
- m_resp_valid pulsed during IDLE and during REQ:
  - No *_resp_valid is produced and the state is unchanged.
  - A later legitimate response is routed normally.
- rst_n dropped in RESP, then released with m_resp_valid = 1:
  - All outputs are 0 during reset.
  - The stale response is not forwarded after release, and the next IFU request is served normally.
